// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs decoded fields into a 32-bit word with a sequential
// word address, behind a single output register stage with valid/ready on both sides.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic signed [31:0]  in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [31:0]         out_addr,
  output logic                out_err,
  output logic [ERR_W-1:0]    err_count
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_S = 2'd2;

  function automatic logic [31:0] encode(
    input logic [1:0]         fmt,
    input logic [6:0]         opcode,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    case (fmt)
      FMT_R:   encode = {f7, rs2, rs1, f3, rd, opcode};
      FMT_I:   encode = {imm[11:0], rs1, f3, rd, opcode};
      FMT_S:   encode = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      default: encode = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
    endcase
  endfunction

  // Out-of-range means the discarded upper bits are not a pure sign extension.
  function automatic logic imm_range_err(
    input logic [1:0]         fmt,
    input logic signed [31:0] imm
  );
    case (fmt)
      FMT_R:   imm_range_err = 1'b0;
      FMT_I,
      FMT_S:   imm_range_err = !((&imm[31:11]) || !(|imm[31:11]));
      default: imm_range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
    sat_inc = (cnt == {ERR_W{1'b1}}) ? cnt : cnt + ERR_W'(1);
  endfunction

  logic              r_vld_p0;
  logic [31:0]       r_instr_p0;
  logic              r_err_p0;
  logic [31:0]       r_addr;
  logic [ERR_W-1:0]  r_err_count;

  logic              w_accept;
  logic              w_retire;
  logic [31:0]       w_instr;
  logic              w_err;

  assign in_ready = !reset && !clear && (!r_vld_p0 || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_vld_p0 && out_ready;
  assign w_instr  = encode(in_fmt, in_opcode, in_funct3, in_funct7,
                           in_rd, in_rs1, in_rs2, in_imm);
  assign w_err    = imm_range_err(in_fmt, in_imm);

  // Stage p0: encoded word register; address and error count advance on retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0    <= 1'b0;
      r_instr_p0  <= 32'd0;
      r_err_p0    <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_err_count <= '0;
    end else if (clear) begin
      r_vld_p0    <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_err_count <= '0;
    end else begin
      if (w_retire) begin
        r_addr <= r_addr + 32'd4;
        if (r_err_p0) r_err_count <= sat_inc(r_err_count);
      end
      if (w_accept) begin
        r_vld_p0   <= 1'b1;
        r_instr_p0 <= w_instr;
        r_err_p0   <= w_err;
      end else if (w_retire) begin
        r_vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p0;
  assign out_instr = r_instr_p0;
  assign out_err   = r_err_p0;
  assign out_addr  = r_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, handshakes, range errors,
// counter saturation, clear/reset during stall and address wrap on a second instance.
module tb_instr_encoder;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  logic               clk;
  logic               reset;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_fmt;
  logic [6:0]         in_opcode;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic signed [31:0] in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_addr;
  logic               out_err;
  logic [7:0]         err_count;

  logic               in_valid2;
  logic               in_ready2;
  logic               out_valid2;
  logic               out_ready2;
  logic [31:0]        out_instr2;
  logic [31:0]        out_addr2;
  logic               out_err2;
  logic [7:0]         err_count2;

  int n_vec = 0;
  int n_mis = 0;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC), .ERR_W(8)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_addr(out_addr2), .out_err(out_err2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic signed [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    set_fields(2'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'sd0);
    step(); step();

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err", out_err, 0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // addi x1,x0,5 with one cycle latency
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    chk("addi_err", out_err, 0);
    out_ready = 1'b1;
    step();
    chk("addi_retire_valid", out_valid, 0);
    chk("addi_retire_addr", out_addr, 32'h4);
    clear = 1'b1;
    #1;
    chk("clear_in_ready", in_ready, 0);
    step();
    clear = 1'b0;
    chk("clear_addr", out_addr, 32'h0);

    // Back-to-back S, B, R
    set_fields(2'd2, OP_S, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'sd8);
    in_valid = 1'b1;
    step();
    chk("sw_instr", out_instr, 32'h0020_A423);
    chk("sw_addr", out_addr, 32'h0);
    chk("sw_in_ready", in_ready, 1);
    set_fields(2'd3, OP_B, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
    step();
    chk("beq_instr", out_instr, 32'hFE20_8EE3);
    chk("beq_addr", out_addr, 32'h4);
    chk("beq_valid", out_valid, 1);
    chk("beq_err", out_err, 0);
    set_fields(2'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'sd0);
    step();
    chk("add_instr", out_instr, 32'h0020_81B3);
    chk("add_addr", out_addr, 32'h8);
    chk("add_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("b2b_drain_valid", out_valid, 0);
    chk("b2b_drain_addr", out_addr, 32'hC);

    // Range errors
    out_ready = 1'b0;
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd2048);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("i2048_instr", out_instr, 32'h8000_0093);
    chk("i2048_err", out_err, 1);
    chk("i2048_errcnt_before", err_count, 0);
    out_ready = 1'b1;
    step();
    chk("i2048_errcnt_after", err_count, 1);
    chk("i2048_addr", out_addr, 32'h10);
    set_fields(2'd3, OP_B, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'sd6);
    in_valid = 1'b1;
    step();
    chk("b6_instr", out_instr, 32'h0000_0363);
    chk("b6_err", out_err, 0);
    set_fields(2'd3, OP_B, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'sd3);
    step();
    chk("b3_instr", out_instr, 32'h0000_0163);
    chk("b3_err", out_err, 1);
    chk("b3_errcnt", err_count, 1);
    set_fields(2'd3, OP_B, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'sd4096);
    step();
    chk("b4096_instr", out_instr, 32'h8000_0063);
    chk("b4096_err", out_err, 1);
    chk("b4096_errcnt", err_count, 2);
    set_fields(2'd2, OP_S, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd2049);
    step();
    chk("s_neg_err", out_err, 1);
    chk("s_neg_errcnt", err_count, 3);
    set_fields(2'd2, OP_S, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd2048);
    step();
    in_valid = 1'b0;
    chk("s_min_err", out_err, 0);
    chk("s_min_instr", out_instr, 32'h8020_A023);
    step();
    chk("range_errcnt_end", err_count, 4);
    chk("range_addr_end", out_addr, 32'h24);

    // Clear during stall with a word held
    out_ready = 1'b0;
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd5);
    in_valid = 1'b1;
    step();
    chk("stall_held_valid", out_valid, 1);
    set_fields(2'd2, OP_S, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'sd8);
    clear = 1'b1;
    #1;
    chk("clear_stall_in_ready", in_ready, 0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear_stall_valid", out_valid, 0);
    chk("clear_stall_addr", out_addr, 32'h0);
    chk("clear_stall_errcnt", err_count, 0);
    set_fields(2'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'sd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_clear_instr", out_instr, 32'h0020_81B3);
    chk("post_clear_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    chk("post_clear_retire_addr", out_addr, 32'h4);

    // Backpressure: word A held five cycles while word B waits
    out_ready = 1'b0;
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd5);
    in_valid = 1'b1;
    step();
    set_fields(2'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'sd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_instr", out_instr, 32'h0050_0093);
      chk("bp_addr", out_addr, 32'h4);
      chk("bp_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_next_instr", out_instr, 32'h0020_81B3);
    chk("bp_next_addr", out_addr, 32'h8);
    chk("bp_next_valid", out_valid, 1);
    step();
    chk("bp_drain_valid", out_valid, 0);
    chk("bp_drain_addr", out_addr, 32'hC);

    // Reset mid-stall discards the held word
    out_ready = 1'b0;
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd2048);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_instr", out_instr, 32'h0);
    chk("rst_stall_err", out_err, 0);
    chk("rst_stall_addr", out_addr, 32'h0);

    // err_count saturation over 300 flagged words
    out_ready = 1'b1;
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd2048);
    in_valid = 1'b1;
    for (int i = 0; i < 101; i++) step();
    chk("sat_count_100", err_count, 100);
    for (int i = 0; i < 199; i++) step();
    in_valid = 1'b0;
    step();
    chk("sat_count_300", err_count, 255);
    chk("sat_addr", out_addr, 32'h4B0);

    // Address wrap on the second instance
    do_clear();
    set_fields(2'd1, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'sd5);
    in_valid2 = 1'b1;
    step();
    chk("wrap_first_addr", out_addr2, 32'hFFFF_FFFC);
    chk("wrap_first_instr", out_instr2, 32'h0050_0093);
    set_fields(2'd0, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'sd0);
    step();
    in_valid2 = 1'b0;
    chk("wrap_second_addr", out_addr2, 32'h0000_0000);
    chk("wrap_second_instr", out_instr2, 32'h0020_81B3);
    step();
    chk("wrap_drain_addr", out_addr2, 32'h0000_0004);
    chk("wrap_drain_valid", out_valid2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
